// File: rtl/ovl_one_hot_pkg.sv
// Shared types and constants for the multi-channel one-hot checker.
// Optional feature macro used by the design: OVL_ONE_HOT_COVER_EN.
package ovl_one_hot_pkg;

    // Which population rule a channel sample must satisfy to pass.
    typedef enum logic [1:0] {
        ONE_HOT      = 2'd0,
        ZERO_ONE_HOT = 2'd1,
        ONE_COLD     = 2'd2
    } ovl_mode_e;

    // Per-channel checker state; exported for debug observation.
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FIRED = 2'd2
    } chan_state_e;

    // Width of the consecutive-violation hold counter.
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/ovl_one_hot_chan.sv
// One checked channel: sample classification, hold FSM, fire pulse,
// sticky flag and saturating fire counter.
// With OVL_ONE_HOT_COVER_EN defined a cover_zero pulse output is added.
module ovl_one_hot_chan
    import ovl_one_hot_pkg::*;
#(
    parameter int        WIDTH = 4,
    parameter ovl_mode_e MODE  = ONE_HOT,
    parameter int        HOLD  = 1,
    parameter int        CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [WIDTH-1:0]   sample,
    output logic               fire,
    output logic               fire_sticky,
    output logic [CNT_W-1:0]   fire_count,
`ifdef OVL_ONE_HOT_COVER_EN
    output logic               cover_zero,
`endif
    output logic [STATE_W-1:0] state_dbg
);

    localparam int                    ONES_W   = $clog2(WIDTH + 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_VAL = HOLD_CNT_W'(HOLD);
    localparam logic [HOLD_CNT_W-1:0] HOLD_ONE = HOLD_CNT_W'(1);

    chan_state_e             state_q, state_d;
    logic [HOLD_CNT_W-1:0]   hold_q, hold_d;
    logic [HOLD_CNT_W-1:0]   hold_inc;
    logic                    fire_d;
    logic [ONES_W-1:0]       ones;
    logic                    pass;
    logic                    viol;

    assign state_dbg = state_q;
    assign hold_inc  = hold_q + HOLD_ONE;

    // Count set bits and classify the sample; unknown bits always violate.
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + ONES_W'(sample[i]);
        end
        case (MODE)
            ONE_HOT:      pass = (ones == ONES_W'(1));
            ZERO_ONE_HOT: pass = (ones <= ONES_W'(1));
            ONE_COLD:     pass = (ones == ONES_W'(WIDTH - 1));
            default:      pass = 1'b0;
        endcase
        viol = !pass || $isunknown(sample);
    end

    // Next state: count consecutive enabled violations, fire once on reaching HOLD.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        fire_d  = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (viol) begin
                        hold_d = HOLD_ONE;
                        if (HOLD_VAL == HOLD_ONE) begin
                            state_d = ST_FIRED;
                            fire_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (viol) begin
                        hold_d = hold_inc;
                        if (hold_inc == HOLD_VAL) begin
                            state_d = ST_FIRED;
                            fire_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end
                ST_FIRED: begin
                    if (!viol) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // FSM state, hold counter and registered fire pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            fire    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            fire    <= fire_d;
        end
    end

    // Sticky flag and saturating count; a fire event overrides a coincident clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fire_sticky <= 1'b0;
            fire_count  <= '0;
        end else if (fire_d) begin
            fire_sticky <= 1'b1;
            if (clear) begin
                fire_count <= CNT_W'(1);
            end else if (fire_count != '1) begin
                fire_count <= fire_count + CNT_W'(1);
            end
        end else if (clear) begin
            fire_sticky <= 1'b0;
            fire_count  <= '0;
        end
    end

`ifdef OVL_ONE_HOT_COVER_EN
    localparam bit COVER_MODE = (MODE == ZERO_ONE_HOT);

    // Pulse when an enabled all-zero sample passes (only meaningful for ZERO_ONE_HOT).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cover_zero <= 1'b0;
        end else begin
            cover_zero <= COVER_MODE && enable && (sample == '0) && !$isunknown(sample);
        end
    end
`endif

endmodule

// File: rtl/ovl_one_hot_multi.sv
// Multi-channel one-hot / zero-one-hot / one-cold checker with hold filter,
// sticky flags and saturating fire counters. Channels are independent.
// Optional macro OVL_ONE_HOT_COVER_EN adds the cover_zero output.
module ovl_one_hot_multi
    import ovl_one_hot_pkg::*;
#(
    parameter int        WIDTH  = 4,
    parameter int        NUM_CH = 2,
    parameter ovl_mode_e MODE   = ONE_HOT,
    parameter int        HOLD   = 1,
    parameter int        CNT_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH*WIDTH-1:0]   test_expr,
    input  logic                      clear,
    output logic [NUM_CH-1:0]         fire,
    output logic [NUM_CH-1:0]         fire_sticky,
    output logic [NUM_CH*CNT_W-1:0]   fire_count,
`ifdef OVL_ONE_HOT_COVER_EN
    output logic [NUM_CH-1:0]         cover_zero,
`endif
    output logic                      any_fire,
    output logic [NUM_CH*STATE_W-1:0] state_dbg
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        ovl_one_hot_chan #(
            .WIDTH (WIDTH),
            .MODE  (MODE),
            .HOLD  (HOLD),
            .CNT_W (CNT_W)
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .clear       (clear),
            .sample      (test_expr[c*WIDTH +: WIDTH]),
            .fire        (fire[c]),
            .fire_sticky (fire_sticky[c]),
            .fire_count  (fire_count[c*CNT_W +: CNT_W]),
`ifdef OVL_ONE_HOT_COVER_EN
            .cover_zero  (cover_zero[c]),
`endif
            .state_dbg   (state_dbg[c*STATE_W +: STATE_W])
        );
    end

    // Summary flag derived from the already-registered per-channel pulses.
    assign any_fire = |fire;

endmodule

// File: tb/tb_ovl_one_hot_multi.sv
// Bench for ovl_one_hot_multi: four instances (one-hot, zero-one-hot, one-cold,
// one-hot with HOLD=3 and 2-bit counters) share one stimulus stream.
module tb_ovl_one_hot_multi;
    import ovl_one_hot_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [7:0] test_expr;

    always #5 clock = ~clock;

    // ---------------- DUT outputs ----------------
    logic [1:0]  fire_w   [4];
    logic [1:0]  sticky_w [4];
    logic        any_w    [4];
    logic [3:0]  dbg_w    [4];
    logic [15:0] cnt_oh, cnt_zoh, cnt_oc;
    logic [3:0]  cnt_h3;
`ifdef OVL_ONE_HOT_COVER_EN
    logic [1:0]  cov_w    [4];
`endif

    ovl_one_hot_multi #(.WIDTH(4), .NUM_CH(2), .MODE(ONE_HOT), .HOLD(1), .CNT_W(8)) u_oh (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr), .clear(clear),
        .fire(fire_w[0]), .fire_sticky(sticky_w[0]), .fire_count(cnt_oh),
`ifdef OVL_ONE_HOT_COVER_EN
        .cover_zero(cov_w[0]),
`endif
        .any_fire(any_w[0]), .state_dbg(dbg_w[0]));

    ovl_one_hot_multi #(.WIDTH(4), .NUM_CH(2), .MODE(ZERO_ONE_HOT), .HOLD(1), .CNT_W(8)) u_zoh (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr), .clear(clear),
        .fire(fire_w[1]), .fire_sticky(sticky_w[1]), .fire_count(cnt_zoh),
`ifdef OVL_ONE_HOT_COVER_EN
        .cover_zero(cov_w[1]),
`endif
        .any_fire(any_w[1]), .state_dbg(dbg_w[1]));

    ovl_one_hot_multi #(.WIDTH(4), .NUM_CH(2), .MODE(ONE_COLD), .HOLD(1), .CNT_W(8)) u_oc (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr), .clear(clear),
        .fire(fire_w[2]), .fire_sticky(sticky_w[2]), .fire_count(cnt_oc),
`ifdef OVL_ONE_HOT_COVER_EN
        .cover_zero(cov_w[2]),
`endif
        .any_fire(any_w[2]), .state_dbg(dbg_w[2]));

    ovl_one_hot_multi #(.WIDTH(4), .NUM_CH(2), .MODE(ONE_HOT), .HOLD(3), .CNT_W(2)) u_h3 (
        .clock(clock), .reset(reset), .enable(enable), .test_expr(test_expr), .clear(clear),
        .fire(fire_w[3]), .fire_sticky(sticky_w[3]), .fire_count(cnt_h3),
`ifdef OVL_ONE_HOT_COVER_EN
        .cover_zero(cov_w[3]),
`endif
        .any_fire(any_w[3]), .state_dbg(dbg_w[3]));

    function automatic int dut_cnt(input int k, input int c);
        case (k)
            0:       return int'(cnt_oh[c*8 +: 8]);
            1:       return int'(cnt_zoh[c*8 +: 8]);
            2:       return int'(cnt_oc[c*8 +: 8]);
            default: return int'(cnt_h3[c*2 +: 2]);
        endcase
    endfunction

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel is described by the length of its current run of enabled
    // violating samples; a fire happens exactly when that run reaches HOLD.
    int hold_k [4] = '{1, 1, 1, 3};
    int max_k  [4] = '{255, 255, 255, 3};
    int mode_k [4] = '{0, 1, 2, 0};   // 0 one-hot, 1 zero-one-hot, 2 one-cold

    int m_run  [4][2];
    int m_cnt  [4][2];
    bit m_fire [4][2];
    bit m_stk  [4][2];
    bit m_cov  [4][2];

    function automatic bit model_viol(input int mode, input logic [3:0] s);
        int n;
        if ($isunknown(s)) return 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(s[i]);
        case (mode)
            0:       return n != 1;
            1:       return n > 1;
            default: return (4 - n) != 1;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin : model_upd
        bit v;
        bit f;
        int nr;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (reset) begin
                    m_run[k][c]  <= 0;
                    m_cnt[k][c]  <= 0;
                    m_fire[k][c] <= 1'b0;
                    m_stk[k][c]  <= 1'b0;
                    m_cov[k][c]  <= 1'b0;
                end else begin
                    v  = model_viol(mode_k[k], test_expr[c*4 +: 4]);
                    f  = 1'b0;
                    nr = 0;
                    if (enable && v) begin
                        nr = m_run[k][c] + 1;
                        f  = (nr == hold_k[k]);
                    end
                    m_run[k][c]  <= nr;
                    m_fire[k][c] <= f;
                    m_cov[k][c]  <= enable && (mode_k[k] == 1) && (test_expr[c*4 +: 4] == 4'b0000);
                    if (f) begin
                        m_stk[k][c] <= 1'b1;
                        m_cnt[k][c] <= clear ? 1 : ((m_cnt[k][c] + 1 > max_k[k]) ? max_k[k] : m_cnt[k][c] + 1);
                    end else if (clear) begin
                        m_stk[k][c] <= 1'b0;
                        m_cnt[k][c] <= 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all four instances against the model.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("model_fire[%0d][%0d]", k, c), int'(fire_w[k][c]), int'(m_fire[k][c]));
                    chk($sformatf("model_sticky[%0d][%0d]", k, c), int'(sticky_w[k][c]), int'(m_stk[k][c]));
                    chk($sformatf("model_count[%0d][%0d]", k, c), dut_cnt(k, c), m_cnt[k][c]);
`ifdef OVL_ONE_HOT_COVER_EN
                    chk($sformatf("model_cover[%0d][%0d]", k, c), int'(cov_w[k][c]), int'(m_cov[k][c]));
`endif
                end
                chk($sformatf("model_any[%0d]", k), int'(any_w[k]), int'(m_fire[k][0] | m_fire[k][1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [7:0] te, input logic en, input logic clr);
        @(negedge clock);
        test_expr = te;
        enable    = en;
        clear     = clr;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        clear  = 1'b0;
        @(negedge clock);
        reset  = 1'b0;
    endtask

    function automatic logic [3:0] gen_chan(input logic [3:0] prev);
        logic [3:0] one;
        one = 4'b0001;
        case ($urandom_range(0, 5))
            0:       return one << $urandom_range(0, 3);
            1:       return 4'b0000;
            2:       return ~(one << $urandom_range(0, 3));
            3:       return 4'($urandom_range(0, 15));
            default: return prev;
        endcase
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [3:0] idle2;
        idle2     = {ST_IDLE, ST_IDLE};
        reset     = 1'b1;
        enable    = 1'b0;
        clear     = 1'b0;
        test_expr = 8'h00;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_fire_oh", int'(fire_w[0]), 0);
        chk("rst_sticky_oh", int'(sticky_w[0]), 0);
        chk("rst_cnt_h3", int'(cnt_h3), 0);
        chk("rst_any_oh", int'(any_w[0]), 0);
        @(negedge clock);
        reset = 1'b0;

        // One-hot, HOLD=1: ch0 legal 3 clocks then all-zero; ch1 stays legal.
        repeat (3) cyc(8'h18, 1'b1, 1'b0);
        chk("oh_pass_nofire", int'(fire_w[0]), 0);
        cyc(8'h10, 1'b1, 1'b0);
        chk("oh_fire", int'(fire_w[0]), 1);
        chk("oh_any", int'(any_w[0]), 1);
        chk("oh_sticky", int'(sticky_w[0]), 1);
        chk("oh_cnt_ch0", dut_cnt(0, 0), 1);
        chk("oh_cnt_ch1", dut_cnt(0, 1), 0);
        cyc(8'h10, 1'b1, 1'b0);
        chk("oh_single_pulse", int'(fire_w[0]), 0);
        chk("oh_cnt_hold", dut_cnt(0, 0), 1);

        // Zero-one-hot: zeros are legal, two bits set is not.
        for (int i = 0; i < 10; i++) begin
            cyc(8'h00, 1'b1, 1'b0);
            chk("zoh_zero_nofire", int'(fire_w[1]), 0);
`ifdef OVL_ONE_HOT_COVER_EN
            chk("zoh_cover_zero", int'(cov_w[1]), 3);
`endif
        end
        cyc(8'h06, 1'b1, 1'b0);
        chk("zoh_fire", int'(fire_w[1]), 1);
        cyc(8'h06, 1'b1, 1'b0);
        chk("zoh_single_pulse", int'(fire_w[1]), 0);
        chk("zoh_cnt", dut_cnt(1, 0), 1);

        // HOLD=3: a short run is filtered, a long run fires once after the third.
        do_reset();
        repeat (2) begin
            cyc(8'h00, 1'b1, 1'b0);
            chk("h3_short_run", int'(fire_w[3]), 0);
        end
        cyc(8'h44, 1'b1, 1'b0);
        chk("h3_short_pass", int'(fire_w[3]), 0);
        for (int k = 1; k <= 13; k++) begin
            cyc(8'h00, 1'b1, 1'b0);
            chk($sformatf("h3_long_run_%0d", k), int'(fire_w[3]), (k == 3) ? 3 : 0);
            if (k == 3) chk("h3_any_both", int'(any_w[3]), 1);
        end
        chk("h3_cnt_ch0", dut_cnt(3, 0), 1);
        chk("h3_cnt_ch1", dut_cnt(3, 1), 1);

        // 2-bit counter: clear, saturate, clear, clear colliding with fire.
        cyc(8'h44, 1'b1, 1'b1);
        chk("h3_clear_cnt", dut_cnt(3, 0), 0);
        chk("h3_clear_sticky", int'(sticky_w[3]), 0);
        repeat (5) begin
            repeat (3) cyc(8'h00, 1'b1, 1'b0);
            cyc(8'h44, 1'b1, 1'b0);
        end
        chk("h3_saturate_ch0", dut_cnt(3, 0), 3);
        chk("h3_saturate_ch1", dut_cnt(3, 1), 3);
        cyc(8'h44, 1'b1, 1'b1);
        chk("h3_clear_again", dut_cnt(3, 0), 0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("h3_clear_vs_fire_fire", int'(fire_w[3]), 3);
        chk("h3_clear_vs_fire_sticky", int'(sticky_w[3]), 3);
        chk("h3_clear_vs_fire_cnt", dut_cnt(3, 0), 1);

        // Asynchronous reset in the middle of a pending run.
        cyc(8'h44, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("h3_pend_nofire", int'(fire_w[3]), 0);
        chk("h3_pend_sticky", int'(sticky_w[3]), 3);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_rst_fire", int'(fire_w[3]), 0);
        chk("async_rst_sticky", int'(sticky_w[3]), 0);
        chk("async_rst_cnt", int'(cnt_h3), 0);
        chk("async_rst_any", int'(any_w[3]), 0);
        chk("async_rst_state", int'(dbg_w[3]), int'(idle2));
        @(negedge clock);
        reset = 1'b0;
        cyc(8'h00, 1'b1, 1'b0);
        chk("post_rst_v1", int'(fire_w[3]), 0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("post_rst_v2", int'(fire_w[3]), 0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("post_rst_v3", int'(fire_w[3]), 3);

        // One-cold: 1110 legal, 1111 fires; disabled violations never fire.
        do_reset();
        cyc(8'hFE, 1'b1, 1'b0);
        chk("oc_ch1_fire", int'(fire_w[2]), 2);
        cyc(8'hEE, 1'b1, 1'b0);
        chk("oc_pass", int'(fire_w[2]), 0);
        repeat (3) begin
            cyc(8'hFF, 1'b0, 1'b0);
            chk("oc_disabled", int'(fire_w[2]), 0);
        end
        cyc(8'hFF, 1'b1, 1'b0);
        chk("oc_reenabled", int'(fire_w[2]), 3);

        // Randomised traffic, with occasional asynchronous reset pulses.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                @(negedge clock);
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
            cyc({gen_chan(test_expr[7:4]), gen_chan(test_expr[3:0])},
                ($urandom_range(0, 19) != 0), ($urandom_range(0, 24) == 0));
        end

        @(posedge clock);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ovl_one_hot_multi.md
OVL_ONE_HOT_MULTI -- requirements
Module: ovl_one_hot_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bits per checked channel (>=2).
REQ-002 SHALL have parameter NUM_CH, default 2, number of independent channels (>=1).
REQ-003 SHALL have parameter MODE, default ONE_HOT; legal values ONE_HOT, ZERO_ONE_HOT, ONE_COLD; applies to all channels.
REQ-004 SHALL have parameter HOLD, default 1, consecutive violating samples before firing (1..255).
REQ-005 SHALL have parameter CNT_W, default 8, width of per-channel saturating fire counter.
REQ-006 SHALL have port clock  input  1  sampling clock; all state on posedge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  checking enable; low = no sampling.
REQ-009 SHALL have port test_expr  input  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port clear  input  1  synchronous clear of sticky flags and counters.
REQ-011 SHALL have port fire  output  NUM_CH  one-cycle violation pulse per channel.
REQ-012 SHALL have port fire_sticky  output  NUM_CH  latched fire per channel.
REQ-013 SHALL have port fire_count  output  NUM_CH*CNT_W  saturating fire count per channel.
REQ-014 SHALL have port any_fire  output  1  OR of fire.

Function
REQ-015 Sample pass: ONE_HOT popcount==1; ZERO_ONE_HOT popcount<=1; ONE_COLD zero-count==1.
REQ-016 Any X/Z bit in a channel sample SHALL count as a violation.
REQ-017 Per-channel FSM: IDLE, PEND, FIRED; hold counter width 8 bits.
REQ-018 IDLE: violating enabled sample -> PEND with counter=1; if HOLD==1, straight to FIRED with fire.
REQ-019 PEND: violating sample increments counter; reaching HOLD -> FIRED with fire; passing sample -> IDLE, counter=0.
REQ-020 FIRED: violating samples produce no further fire; passing sample -> IDLE.
REQ-021 enable low at posedge SHALL force IDLE, counter 0, fire 0; sticky and counts hold.
REQ-022 fire SHALL be registered: high exactly one cycle, in the cycle following the HOLD-th consecutive violating posedge.
REQ-023 On fire, fire_sticky SHALL set and fire_count SHALL increment, saturating at 2^CNT_W-1.
REQ-024 clear SHALL zero fire_sticky and fire_count next posedge; FSMs unaffected.
REQ-025 clear coincident with a fire event: fire wins, sticky=1, count=1.
REQ-026 any_fire SHALL be combinational OR of registered fire.
REQ-027 Channels SHALL be fully independent; simultaneous fires on several channels all reported same cycle.

Reset
REQ-028 reset SHALL asynchronously force all FSMs IDLE, counters 0, fire/fire_sticky/fire_count/any_fire 0, including mid-PEND.
REQ-029 After deassert, first evaluated sample SHALL be at the next posedge with enable high.

Configuration
REQ-030 Macro OVL_ONE_HOT_COVER_EN defined: add output cover_zero [NUM_CH], registered one-cycle pulse when an enabled sample is all-zero and passes (ZERO_ONE_HOT only; constant 0 otherwise).
REQ-031 Macro undefined: cover_zero port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package ovl_one_hot_pkg SHALL hold the mode enum, FSM state enum and hold-counter width constant.
REQ-033 Per-channel FSM, counter and sticky logic SHALL be sub-module ovl_one_hot_chan, generated NUM_CH times.

Verification
REQ-034 ONE_HOT, HOLD=1: ch0 4'b1000 3 clocks, then 4'b0000 -> fire[0] single pulse, fire_count[0]=1, ch1 unaffected.
REQ-035 ZERO_ONE_HOT: 4'b0000 10 clocks -> no fire; 4'b0110 -> fire one pulse; cover_zero pulses during zeros when OVL_ONE_HOT_COVER_EN defined.
REQ-036 HOLD=3: 2 violating samples then 4'b0100 -> no fire; 13 violating samples -> one fire after 3rd, count=1.
REQ-037 CNT_W=2: 5 separated violation episodes -> fire_count=3 saturated; clear -> 0; clear with simultaneous fire -> 1.
REQ-038 reset asserted mid-PEND (HOLD=3, after 2 violations) -> all outputs 0; post-reset needs 3 fresh violations to fire.
REQ-039 ONE_COLD, NUM_CH=2: ch0 4'b1110 passes, ch1 4'b1111 fires; enable low during violation -> no fire.
